// File: rtl/cfg_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_reg_bank
//  Description : Parametrised configuration/data register bank with one write
//                port, two independent read ports (latency 1 or 2), per-
//                register reset values, a read-only mask, an access-error
//                pulse and a flat always-valid tap bus of the low registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module cfg_reg_bank #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int DEPTH   = 16,
    parameter int NUM_TAP = 4,
    parameter logic [DEPTH*DATA_W-1:0] RST_VAL =
        ((DEPTH*DATA_W)'(8'h80) << (2*DATA_W)) |
        ((DEPTH*DATA_W)'(8'h01) << (3*DATA_W)),
    parameter logic [DEPTH-1:0] RO_MASK = '0,
    parameter int RD_LAT  = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      WrEn,
    input  logic [ADDR_W-1:0]         WrAddr,
    input  logic [DATA_W-1:0]         WrData,
    input  logic                      RdEnA,
    input  logic [ADDR_W-1:0]         RdAddrA,
    output logic [DATA_W-1:0]         RdDataA,
    output logic                      RdValidA,
    input  logic                      RdEnB,
    input  logic [ADDR_W-1:0]         RdAddrB,
    output logic [DATA_W-1:0]         RdDataB,
    output logic                      RdValidB,
    output logic                      AccErr,
    output logic [NUM_TAP*DATA_W-1:0] TAP
);

    localparam int c_SLOTS = 1 << ADDR_W;

    // Full address space view: unimplemented slots read as zero, count as
    // out-of-range and reject writes. Only DEPTH slots hold storage.
    logic [DATA_W-1:0] w_mem_full [c_SLOTS];
    logic [c_SLOTS-1:0] w_blocked;
    logic [c_SLOTS-1:0] w_oor;

    logic w_wr_ok;
    logic w_wr_err;
    logic w_rd_err_a;
    logic w_rd_err_b;

    assign w_wr_ok    = WrEn  & ~w_blocked[WrAddr];
    assign w_wr_err   = WrEn  &  w_blocked[WrAddr];
    assign w_rd_err_a = RdEnA &  w_oor[RdAddrA];
    assign w_rd_err_b = RdEnB &  w_oor[RdAddrB];

    genvar gi;
    generate
        for (gi = 0; gi < c_SLOTS; gi++) begin : g_slot
            if (gi < DEPTH) begin : g_impl
                assign w_oor[gi] = 1'b0;
                if (RO_MASK[gi]) begin : g_ro
                    // Read-only register: a constant, no storage needed
                    assign w_blocked[gi]  = 1'b1;
                    assign w_mem_full[gi] = RST_VAL[gi*DATA_W +: DATA_W];
                end else begin : g_rw
                    logic [DATA_W-1:0] reg_q;
                    logic [DATA_W-1:0] reg_d;
                    assign w_blocked[gi]  = 1'b0;
                    assign reg_d = (w_wr_ok && (WrAddr == ADDR_W'(gi))) ? WrData : reg_q;
                    // Storage register: reset value, else accept matching write
                    always_ff @(posedge CLK) begin
                        if (RST) reg_q <= RST_VAL[gi*DATA_W +: DATA_W];
                        else     reg_q <= reg_d;
                    end
                    assign w_mem_full[gi] = reg_q;
                end
            end else begin : g_unimpl
                assign w_oor[gi]      = 1'b1;
                assign w_blocked[gi]  = 1'b1;
                assign w_mem_full[gi] = '0;
            end
        end

        for (gi = 0; gi < NUM_TAP; gi++) begin : g_tap
            assign TAP[gi*DATA_W +: DATA_W] = w_mem_full[gi];
        end
    endgenerate

    // First read stage. Reads sample storage before this edge's write lands,
    // which gives read-before-write on a same-address collision. Data only
    // updates on a request so an idle port holds its last value.
    logic [DATA_W-1:0] rd_data_a_q, rd_data_b_q;
    logic              rd_valid_a_q, rd_valid_b_q;
    logic              acc_err_q;

    // Stage-1 read capture and access-error pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
            acc_err_q    <= 1'b0;
        end else begin
            rd_valid_a_q <= RdEnA;
            rd_valid_b_q <= RdEnB;
            if (RdEnA) rd_data_a_q <= w_mem_full[RdAddrA];
            if (RdEnB) rd_data_b_q <= w_mem_full[RdAddrB];
            acc_err_q    <= w_wr_err | w_rd_err_a | w_rd_err_b;
        end
    end

    assign AccErr = acc_err_q;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] rd_data_a_q2, rd_data_b_q2;
            logic              rd_valid_a_q2, rd_valid_b_q2;
            // Optional output stage: delays data and valid by one more cycle
            always_ff @(posedge CLK) begin
                if (RST) begin
                    rd_data_a_q2  <= '0;
                    rd_data_b_q2  <= '0;
                    rd_valid_a_q2 <= 1'b0;
                    rd_valid_b_q2 <= 1'b0;
                end else begin
                    rd_valid_a_q2 <= rd_valid_a_q;
                    rd_valid_b_q2 <= rd_valid_b_q;
                    if (rd_valid_a_q) rd_data_a_q2 <= rd_data_a_q;
                    if (rd_valid_b_q) rd_data_b_q2 <= rd_data_b_q;
                end
            end
            assign RdDataA  = rd_data_a_q2;
            assign RdDataB  = rd_data_b_q2;
            assign RdValidA = rd_valid_a_q2;
            assign RdValidB = rd_valid_b_q2;
        end else begin : g_lat1
            assign RdDataA  = rd_data_a_q;
            assign RdDataB  = rd_data_b_q;
            assign RdValidA = rd_valid_a_q;
            assign RdValidB = rd_valid_b_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cfg_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cfg_reg_bank
//  Description : Directed self-checking bench for cfg_reg_bank. Three
//                instances share stimulus: u0 defaults, u1 RD_LAT=2 with
//                reg3 read-only, u2 DEPTH=12.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_reg_bank;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       WrEn = 1'b0;
    logic [3:0] WrAddr = '0;
    logic [7:0] WrData = '0;
    logic       RdEnA = 1'b0;
    logic [3:0] RdAddrA = '0;
    logic       RdEnB = 1'b0;
    logic [3:0] RdAddrB = '0;

    logic [7:0]  rda0, rdb0, rda1, rdb1, rda2, rdb2;
    logic        rva0, rvb0, rva1, rvb1, rva2, rvb2;
    logic        err0, err1, err2;
    logic [31:0] tap0, tap1, tap2;

    int compared   = 0;
    int mismatched = 0;

    always #5 CLK = ~CLK;

    cfg_reg_bank u0 (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdDataA(rda0), .RdValidA(rva0),
        .RdEnB(RdEnB), .RdAddrB(RdAddrB), .RdDataB(rdb0), .RdValidB(rvb0),
        .AccErr(err0), .TAP(tap0)
    );

    cfg_reg_bank #(.RD_LAT(2), .RO_MASK(16'h0008)) u1 (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdDataA(rda1), .RdValidA(rva1),
        .RdEnB(RdEnB), .RdAddrB(RdAddrB), .RdDataB(rdb1), .RdValidB(rvb1),
        .AccErr(err1), .TAP(tap1)
    );

    cfg_reg_bank #(.DEPTH(12)) u2 (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdDataA(rda2), .RdValidA(rva2),
        .RdEnB(RdEnB), .RdAddrB(RdAddrB), .RdDataB(rdb2), .RdValidB(rvb2),
        .AccErr(err2), .TAP(tap2)
    );

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        compared++; if (tap0 !== 32'h0180_0000) begin mismatched++; $display("FAIL reset_tap0: got %h want %h", tap0, 32'h0180_0000); end
        compared++; if (tap1 !== 32'h0180_0000) begin mismatched++; $display("FAIL reset_tap1: got %h want %h", tap1, 32'h0180_0000); end
        compared++; if (tap2 !== 32'h0180_0000) begin mismatched++; $display("FAIL reset_tap2: got %h want %h", tap2, 32'h0180_0000); end
        compared++; if ({rva0, rvb0, rva1, rvb1, rva2, rvb2} !== 6'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 000000", {rva0, rvb0, rva1, rvb1, rva2, rvb2}); end
        compared++; if ({err0, err1, err2} !== 3'b0) begin mismatched++; $display("FAIL reset_err: got %b want 000", {err0, err1, err2}); end
        compared++; if ({rda0, rdb0, rda1} !== 24'h0) begin mismatched++; $display("FAIL reset_data: got %h want 000000", {rda0, rdb0, rda1}); end
    endtask

    task automatic test_write_read();
        WrEn = 1'b1; WrAddr = 4'd5; WrData = 8'h5A;
        tick();
        WrEn = 1'b0;
        RdEnA = 1'b1; RdAddrA = 4'd5;
        tick();
        RdEnA = 1'b0;
        compared++; if ({rva0, rda0} !== {1'b1, 8'h5A}) begin mismatched++; $display("FAIL wr_rd_lat1: got v=%b d=%h want v=1 d=5a", rva0, rda0); end
        compared++; if (rva1 !== 1'b0) begin mismatched++; $display("FAIL wr_rd_lat2_early: got v=%b want 0", rva1); end
        tick();
        compared++; if ({rva0, rda0} !== {1'b0, 8'h5A}) begin mismatched++; $display("FAIL wr_rd_lat1_hold: got v=%b d=%h want v=0 d=5a", rva0, rda0); end
        compared++; if ({rva1, rda1} !== {1'b1, 8'h5A}) begin mismatched++; $display("FAIL wr_rd_lat2: got v=%b d=%h want v=1 d=5a", rva1, rda1); end
        tick();
        compared++; if ({rva1, rda1} !== {1'b0, 8'h5A}) begin mismatched++; $display("FAIL wr_rd_lat2_pulse: got v=%b d=%h want v=0 d=5a", rva1, rda1); end
    endtask

    task automatic test_dual_port();
        RdEnA = 1'b1; RdAddrA = 4'd5;
        RdEnB = 1'b1; RdAddrB = 4'd5;
        tick();
        RdEnA = 1'b0; RdEnB = 1'b0;
        compared++; if ({rva0, rda0, rvb0, rdb0} !== {1'b1, 8'h5A, 1'b1, 8'h5A}) begin mismatched++; $display("FAIL dual_same_addr: got A=%b/%h B=%b/%h want 1/5a 1/5a", rva0, rda0, rvb0, rdb0); end
        tick();
    endtask

    task automatic test_collision();
        WrEn = 1'b1; WrAddr = 4'd1; WrData = 8'h11;
        tick();
        WrData = 8'h22;
        RdEnB = 1'b1; RdAddrB = 4'd1;
        tick();
        WrEn = 1'b0;
        compared++; if ({rvb0, rdb0} !== {1'b1, 8'h11}) begin mismatched++; $display("FAIL collision_old: got v=%b d=%h want v=1 d=11", rvb0, rdb0); end
        tick();
        RdEnB = 1'b0;
        compared++; if ({rvb0, rdb0} !== {1'b1, 8'h22}) begin mismatched++; $display("FAIL collision_new: got v=%b d=%h want v=1 d=22", rvb0, rdb0); end
        compared++; if (tap0[15:8] !== 8'h22) begin mismatched++; $display("FAIL collision_tap: got %h want 22", tap0[15:8]); end
        compared++; if ({rvb1, rdb1} !== {1'b1, 8'h11}) begin mismatched++; $display("FAIL collision_lat2_old: got v=%b d=%h want v=1 d=11", rvb1, rdb1); end
        tick();
        compared++; if ({rvb1, rdb1} !== {1'b1, 8'h22}) begin mismatched++; $display("FAIL collision_lat2_new: got v=%b d=%h want v=1 d=22", rvb1, rdb1); end
        tick();
    endtask

    task automatic test_read_only();
        WrEn = 1'b1; WrAddr = 4'd3; WrData = 8'hFF;
        tick();
        WrEn = 1'b0;
        compared++; if (err1 !== 1'b1) begin mismatched++; $display("FAIL ro_err: got %b want 1", err1); end
        compared++; if (tap1[31:24] !== 8'h01) begin mismatched++; $display("FAIL ro_hold: got %h want 01", tap1[31:24]); end
        compared++; if ({err0, tap0[31:24]} !== {1'b0, 8'hFF}) begin mismatched++; $display("FAIL rw_write: got err=%b reg3=%h want err=0 reg3=ff", err0, tap0[31:24]); end
        tick();
        compared++; if (err1 !== 1'b0) begin mismatched++; $display("FAIL ro_err_pulse: got %b want 0", err1); end
    endtask

    task automatic test_out_of_range();
        RdEnA = 1'b1; RdAddrA = 4'd14;
        tick();
        RdEnA = 1'b0;
        compared++; if ({err2, rva2, rda2} !== {1'b1, 1'b1, 8'h00}) begin mismatched++; $display("FAIL oor_read: got err=%b v=%b d=%h want err=1 v=1 d=00", err2, rva2, rda2); end
        compared++; if ({err0, rva0} !== 2'b01) begin mismatched++; $display("FAIL oor_read_inrange_dut: got err=%b v=%b want err=0 v=1", err0, rva0); end
        WrEn = 1'b1; WrAddr = 4'd13; WrData = 8'h77;
        tick();
        WrEn = 1'b0;
        compared++; if (err2 !== 1'b1) begin mismatched++; $display("FAIL oor_write_err: got %b want 1", err2); end
        compared++; if (tap2 !== 32'hFF80_2200) begin mismatched++; $display("FAIL oor_write_tap: got %h want ff802200", tap2); end
        compared++; if (err0 !== 1'b0) begin mismatched++; $display("FAIL oor_write_inrange_dut: got %b want 0", err0); end
        tick();
        compared++; if (err2 !== 1'b0) begin mismatched++; $display("FAIL oor_err_pulse: got %b want 0", err2); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp0 [4];
        logic [7:0] exp1 [4];
        exp0[0] = 8'h00; exp0[1] = 8'h22; exp0[2] = 8'h80; exp0[3] = 8'hFF;
        exp1[0] = 8'h00; exp1[1] = 8'h22; exp1[2] = 8'h80; exp1[3] = 8'h01;
        for (int k = 0; k < 4; k++) begin
            RdEnA = 1'b1; RdAddrA = 4'(k);
            tick();
            compared++; if ({rva0, rda0} !== {1'b1, exp0[k]}) begin mismatched++; $display("FAIL stream_lat1[%0d]: got v=%b d=%h want v=1 d=%h", k, rva0, rda0, exp0[k]); end
            if (k >= 1) begin
                compared++; if ({rva1, rda1} !== {1'b1, exp1[k-1]}) begin mismatched++; $display("FAIL stream_lat2[%0d]: got v=%b d=%h want v=1 d=%h", k-1, rva1, rda1, exp1[k-1]); end
            end
        end
        RST = 1'b1; RdAddrA = 4'd4;
        tick();
        RST = 1'b0; RdEnA = 1'b0;
        compared++; if ({rva0, rva1, rda0} !== {1'b0, 1'b0, 8'h00}) begin mismatched++; $display("FAIL stream_rst: got v0=%b v1=%b d0=%h want 0 0 00", rva0, rva1, rda0); end
        compared++; if ({tap0, tap2} !== {32'h0180_0000, 32'h0180_0000}) begin mismatched++; $display("FAIL stream_rst_tap: got %h %h want 01800000 01800000", tap0, tap2); end
        tick();
        compared++; if ({rva0, rva1, rva2} !== 3'b0) begin mismatched++; $display("FAIL stream_no_stale: got %b want 000", {rva0, rva1, rva2}); end
        RdEnA = 1'b1; RdAddrA = 4'd5;
        tick();
        RdEnA = 1'b0;
        compared++; if ({rva0, rda0} !== {1'b1, 8'h00}) begin mismatched++; $display("FAIL post_rst_reg5: got v=%b d=%h want v=1 d=00", rva0, rda0); end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_dual_port();
        test_collision();
        test_read_only();
        test_out_of_range();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
